// File: rtl/axi_dac_jesd204_datapath_sync_if.sv
// DMA-to-framer sample bus for the JESD204 DAC transmit datapath.
// The datapath uses the slave modport. The DMA/framer side uses the master modport.
interface axi_dac_jesd204_datapath_sync_if #(
    parameter int NUM_CHANNELS    = 2,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int SAMPLE_WIDTH    = 16
);
    localparam int WORD_WIDTH = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH;

    logic [WORD_WIDTH-1:0] dma_data;
    logic                  dma_valid;
    logic                  dma_ready;
    logic [WORD_WIDTH-1:0] dac_data;
    logic                  dac_valid;

    modport master (
        output dma_data, dma_valid,
        input  dma_ready, dac_data, dac_valid
    );

    modport slave (
        input  dma_data, dma_valid,
        output dma_ready, dac_data, dac_valid
    );
endinterface

// File: rtl/axi_dac_jesd204_datapath_sync.sv
// Transmit datapath for the JESD204 DAC, running in the dac_clk domain.
// Each channel selects its source per lane. Start is armed/run. Underflows are counted.
module axi_dac_jesd204_datapath_sync #(
    parameter int NUM_CHANNELS    = 2,
    parameter int DATA_PATH_WIDTH = 4,
    parameter int SAMPLE_WIDTH    = 16,
    parameter int UNDERFLOW_HOLD  = 0
) (
    input  logic                                dac_clk,
    input  logic                                dac_rst,
    input  logic                                dac_sync,
    input  logic                                dac_stop,
    input  logic                                dac_ext_sync_en,
    input  logic                                dac_ext_sync,
    input  logic [NUM_CHANNELS-1:0]             dac_enable,
    input  logic [2*NUM_CHANNELS-1:0]           dac_data_sel,
    input  logic [NUM_CHANNELS*SAMPLE_WIDTH-1:0] dac_pat_data,
    input  logic                                dac_dds_format,
    axi_dac_jesd204_datapath_sync_if.slave      bus,
    output logic                                dac_dunf,
    input  logic                                dac_unf_clr,
    output logic [15:0]                         dac_unf_count,
    output logic [1:0]                          dac_state
);
    localparam int WORD_WIDTH = NUM_CHANNELS * DATA_PATH_WIDTH * SAMPLE_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    state_t                  state, state_next;
    logic [SAMPLE_WIDTH-1:0] ramp;
    logic [WORD_WIDTH-1:0]   hold_word;
    logic [WORD_WIDTH-1:0]   dma_word;
    logic [WORD_WIDTH-1:0]   data_next;
    logic [SAMPLE_WIDTH-1:0] smp;
    logic                    any_dma;
    logic                    underflow;
    logic                    accept;

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (dac_sync) state_next = dac_ext_sync_en ? ST_ARMED : ST_RUN;
            ST_ARMED: if (dac_ext_sync) state_next = ST_RUN;
            default:  state_next = state;
        endcase
        if (dac_stop) state_next = ST_IDLE;
    end

    always_comb begin
        any_dma = 1'b0;
        for (int i = 0; i < NUM_CHANNELS; i++)
            if (dac_enable[i] && dac_data_sel[2*i +: 2] == 2'd0) any_dma = 1'b1;
    end

    // The reset term keeps a word from being accepted while the block is held in reset.
    assign bus.dma_ready = (state == ST_RUN) && any_dma && !dac_rst;
    assign accept        = bus.dma_ready && bus.dma_valid;
    assign underflow     = bus.dma_ready && !bus.dma_valid;
    assign dma_word      = bus.dma_valid ? bus.dma_data
                         : ((UNDERFLOW_HOLD != 0) ? hold_word : '0);
    assign dac_state     = state;

    always_comb begin
        data_next = '0;
        smp       = '0;
        for (int i = 0; i < NUM_CHANNELS; i++) begin
            for (int k = 0; k < DATA_PATH_WIDTH; k++) begin
                smp = '0;
                if (dac_enable[i]) begin
                    case (dac_data_sel[2*i +: 2])
                        2'd0:    smp = dma_word[(i*DATA_PATH_WIDTH+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        2'd2:    smp = ramp + SAMPLE_WIDTH'(k);
                        2'd3:    smp = dac_pat_data[i*SAMPLE_WIDTH +: SAMPLE_WIDTH];
                        default: smp = '0;
                    endcase
                end
                // Offset-binary conversion is last, so disabled and zero lanes are converted too.
                if (dac_dds_format) smp[SAMPLE_WIDTH-1] = ~smp[SAMPLE_WIDTH-1];
                data_next[(i*DATA_PATH_WIDTH+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH] = smp;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments, so all registers update together at the edge.
    always_ff @(posedge dac_clk) begin
        if (dac_rst) begin
            state         <= ST_IDLE;
            ramp          <= '0;
            hold_word     <= '0;
            bus.dac_data  <= '0;
            bus.dac_valid <= 1'b0;
            dac_dunf      <= 1'b0;
            dac_unf_count <= '0;
        end else begin
            state <= state_next;

            if (state_next == ST_RUN && state != ST_RUN)
                ramp <= '0;
            else if (state == ST_RUN)
                ramp <= ramp + SAMPLE_WIDTH'(DATA_PATH_WIDTH);

            if (accept) hold_word <= bus.dma_data;

            bus.dac_valid <= (state == ST_RUN);
            bus.dac_data  <= (state == ST_RUN) ? data_next : '0;

            dac_dunf <= underflow;
            if (dac_unf_clr)
                dac_unf_count <= '0;
            else if (underflow && dac_unf_count != 16'hFFFF)
                dac_unf_count <= dac_unf_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_axi_dac_jesd204_datapath_sync.sv
// Directed bench for axi_dac_jesd204_datapath_sync with two instances: zero-on-underflow and hold-on-underflow.
// Both instances share all stimulus. Expected words are hand-built from the sample layout.
module tb_axi_dac_jesd204_datapath_sync;
    localparam int NC = 2;
    localparam int DW = 4;
    localparam int SW = 16;
    localparam int WW = NC * DW * SW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            sync = 1'b0, stop = 1'b0, ext_en = 1'b0, ext_sync = 1'b0;
    logic [NC-1:0]   enable = '0;
    logic [2*NC-1:0] sel = '0;
    logic [NC*SW-1:0] pat = '0;
    logic            dds = 1'b0;
    logic            unf_clr = 1'b0;
    logic            dunf0, dunf1;
    logic [15:0]     cnt0, cnt1;
    logic [1:0]      st0, st1;

    int checks = 0;
    int failures = 0;

    axi_dac_jesd204_datapath_sync_if #(.NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DW), .SAMPLE_WIDTH(SW)) bus0 ();
    axi_dac_jesd204_datapath_sync_if #(.NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DW), .SAMPLE_WIDTH(SW)) bus1 ();

    assign bus1.dma_data  = bus0.dma_data;
    assign bus1.dma_valid = bus0.dma_valid;

    axi_dac_jesd204_datapath_sync #(.NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DW), .SAMPLE_WIDTH(SW),
        .UNDERFLOW_HOLD(0)) dut0 (
        .dac_clk(clk), .dac_rst(rst), .dac_sync(sync), .dac_stop(stop),
        .dac_ext_sync_en(ext_en), .dac_ext_sync(ext_sync), .dac_enable(enable),
        .dac_data_sel(sel), .dac_pat_data(pat), .dac_dds_format(dds), .bus(bus0.slave),
        .dac_dunf(dunf0), .dac_unf_clr(unf_clr), .dac_unf_count(cnt0), .dac_state(st0)
    );

    axi_dac_jesd204_datapath_sync #(.NUM_CHANNELS(NC), .DATA_PATH_WIDTH(DW), .SAMPLE_WIDTH(SW),
        .UNDERFLOW_HOLD(1)) dut1 (
        .dac_clk(clk), .dac_rst(rst), .dac_sync(sync), .dac_stop(stop),
        .dac_ext_sync_en(ext_en), .dac_ext_sync(ext_sync), .dac_enable(enable),
        .dac_data_sel(sel), .dac_pat_data(pat), .dac_dds_format(dds), .bus(bus1.slave),
        .dac_dunf(dunf1), .dac_unf_clr(unf_clr), .dac_unf_count(cnt1), .dac_state(st1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [WW-1:0] actual, input logic [WW-1:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got %h expected %h", tag, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample k of channel 0 is a*, sample k of channel 1 is b*.
    function automatic logic [WW-1:0] lanes(input logic [15:0] a0, a1, a2, a3, b0, b1, b2, b3);
        return {b3, b2, b1, b0, a3, a2, a1, a0};
    endfunction

    function automatic logic [WW-1:0] count_word(input logic [15:0] base);
        return lanes(base, base + 16'd1, base + 16'd2, base + 16'd3,
                     base + 16'd4, base + 16'd5, base + 16'd6, base + 16'd7);
    endfunction

    function automatic logic [WW-1:0] ramp_pat(input logic [15:0] r);
        return lanes(r, r + 16'd1, r + 16'd2, r + 16'd3, 16'h1234, 16'h1234, 16'h1234, 16'h1234);
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [WW-1:0] w;
        logic [WW-1:0] a;
        logic [WW-1:0] d;
        bus0.dma_data  = '0;
        bus0.dma_valid = 1'b0;

        // Reset values
        tick(); tick();
        check("rst_state", WW'(st0), WW'(0));
        check("rst_valid", WW'(bus0.dac_valid), WW'(0));
        check("rst_data", bus0.dac_data, '0);
        check("rst_ready", WW'(bus0.dma_ready), WW'(0));
        check("rst_dunf", WW'(dunf0), WW'(0));
        check("rst_count", WW'(cnt0), WW'(0));
        rst = 1'b0;

        // Start without external sync, both channels on DMA
        enable = 2'b11; sel = 4'b0000; bus0.dma_valid = 1'b1;
        bus0.dma_data = count_word(16'h1000);
        sync = 1'b1;
        tick();                                    // n+1
        sync = 1'b0;
        check("start_state_run", WW'(st0), WW'(2));
        check("start_ready", WW'(bus0.dma_ready), WW'(1));
        check("start_valid_n1", WW'(bus0.dac_valid), WW'(0));
        w = count_word(16'h2000);
        bus0.dma_data = w;
        tick();                                    // n+2
        check("start_valid_n2", WW'(bus0.dac_valid), WW'(1));
        check("dma_pass_1", bus0.dac_data, w);
        w = count_word(16'h3000);
        bus0.dma_data = w;
        tick();
        check("dma_pass_2", bus0.dac_data, w);

        // External sync arming
        stop = 1'b1;
        tick();
        stop = 1'b0;
        check("stop_state", WW'(st0), WW'(0));
        check("stop_ready", WW'(bus0.dma_ready), WW'(0));
        tick();
        check("stop_valid", WW'(bus0.dac_valid), WW'(0));
        check("stop_data", bus0.dac_data, '0);
        ext_en = 1'b1; sync = 1'b1;
        tick();
        sync = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("armed_state", WW'(st0), WW'(1));
            check("armed_ready", WW'(bus0.dma_ready), WW'(0));
            if (i == 9) ext_sync = 1'b1;
            tick();
        end
        ext_sync = 1'b0; ext_en = 1'b0;
        check("armed_to_run", WW'(st0), WW'(2));

        // Ramp on channel 0, pattern on channel 1
        stop = 1'b1;
        tick();
        stop = 1'b0;
        sel = 4'b1110;
        pat = {16'h1234, 16'h0000};
        sync = 1'b1;
        tick();                                    // n+1, R = 0
        sync = 1'b0;
        check("ramp_no_ready", WW'(bus0.dma_ready), WW'(0));
        tick();
        check("ramp_0", bus0.dac_data, ramp_pat(16'h0000));
        tick();
        check("ramp_4", bus0.dac_data, ramp_pat(16'h0004));
        repeat (16382) tick();
        check("ramp_fffc", bus0.dac_data, ramp_pat(16'hFFFC));
        tick();
        check("ramp_wrap", bus0.dac_data, ramp_pat(16'h0000));

        // Underflow for three cycles
        stop = 1'b1;
        tick();
        stop = 1'b0;
        sel = 4'b0000; bus0.dma_valid = 1'b1;
        sync = 1'b1;
        tick();                                    // n+1
        sync = 1'b0;
        a = count_word(16'h4000);
        bus0.dma_data = a;
        tick();                                    // n+2
        check("unf_pre_word", bus0.dac_data, a);
        bus0.dma_valid = 1'b0;
        bus0.dma_data = count_word(16'h5000);
        d = count_word(16'h6000);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("unf_dunf_zero", WW'(dunf0), WW'(1));
            check("unf_dunf_hold", WW'(dunf1), WW'(1));
            check("unf_data_zero", bus0.dac_data, '0);
            check("unf_data_hold", bus1.dac_data, a);
            if (i == 2) begin
                bus0.dma_valid = 1'b1;
                bus0.dma_data = d;
            end
        end
        tick();
        check("unf_resume_data", bus0.dac_data, d);
        check("unf_resume_dunf", WW'(dunf0), WW'(0));
        check("unf_count_zero", WW'(cnt0), WW'(3));
        check("unf_count_hold", WW'(cnt1), WW'(3));
        bus0.dma_valid = 1'b0; unf_clr = 1'b1;
        tick();
        check("clr_wins_count", WW'(cnt0), WW'(0));
        check("clr_wins_dunf", WW'(dunf0), WW'(1));
        bus0.dma_valid = 1'b1; unf_clr = 1'b0;
        tick();
        check("clr_after_count", WW'(cnt0), WW'(0));
        check("clr_after_dunf", WW'(dunf0), WW'(0));

        // Offset-binary with channel 0 disabled
        enable = 2'b10; dds = 1'b1;
        bus0.dma_data = lanes(16'h5555, 16'h5555, 16'h5555, 16'h5555,
                              16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        tick();
        check("dds_format", bus0.dac_data, lanes(16'h8000, 16'h8000, 16'h8000, 16'h8000,
                                                 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF));
        dds = 1'b0; enable = 2'b11;

        // Stop and sync together in RUN
        stop = 1'b1; sync = 1'b1;
        tick();
        stop = 1'b0; sync = 1'b0;
        check("stop_sync_state", WW'(st0), WW'(0));
        check("stop_sync_ready", WW'(bus0.dma_ready), WW'(0));
        tick();
        check("stop_sync_valid", WW'(bus0.dac_valid), WW'(0));
        check("stop_sync_data", bus0.dac_data, '0);

        // Reset mid-RUN, then ramp restart; channel 1 on DMA
        sel = 4'b0010;
        sync = 1'b1;
        tick();
        sync = 1'b0;
        tick(); tick();
        rst = 1'b1;
        #1;
        check("rst_blocks_ready", WW'(bus0.dma_ready), WW'(0));
        tick();
        check("midrst_state", WW'(st0), WW'(0));
        check("midrst_valid", WW'(bus0.dac_valid), WW'(0));
        check("midrst_data", bus0.dac_data, '0);
        rst = 1'b0;
        sync = 1'b1;
        tick();                                    // n+1
        sync = 1'b0;
        bus0.dma_data = count_word(16'h7100);
        tick();
        check("ramp_restart", bus0.dac_data, lanes(16'h0000, 16'h0001, 16'h0002, 16'h0003,
                                                   16'h7104, 16'h7105, 16'h7106, 16'h7107));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/axi_dac_jesd204_datapath_sync.md
# axi_dac_jesd204_datapath_sync

Parametrised transmit datapath for the JESD204 DAC core, in the `dac_clk` domain between the DMA/FIFO and the link-layer transmit framer. Per channel, it selects DMA data, zero, a ramp or a constant pattern. It adds a valid/ready handshake toward the DMA, an armed start gated by an external sync, underflow detection with a saturating counter, and optional offset-binary conversion. Configuration inputs arrive already synchronised to `dac_clk` from the common and per-channel register blocks.

## Interface
Parameters:
- NUM_CHANNELS, 2, number of converter channels (1..16)
- DATA_PATH_WIDTH, 4, samples per channel per clock (1..8)
- SAMPLE_WIDTH, 16, bits per sample (12..16)
- UNDERFLOW_HOLD, 0, 0: DMA-sourced lanes output zero on underflow; 1: they repeat the last accepted DMA word

Ports:
- Clocking and reset: one clock, `dac_clk`; reset is `dac_rst`, synchronous and active-high.
- dac_clk  in  1  datapath clock
- dac_rst  in  1  synchronous active-high reset
- dac_sync  in  1  start pulse (arm/run)
- dac_stop  in  1  stop pulse, returns to IDLE
- dac_ext_sync_en  in  1  1: start waits for dac_ext_sync
- dac_ext_sync  in  1  external trigger, level sampled in ARMED
- dac_enable  in  NUM_CHANNELS  per-channel enable
- dac_data_sel  in  2*NUM_CHANNELS  per-channel source: 0 DMA, 1 zero, 2 ramp, 3 pattern
- dac_pat_data  in  NUM_CHANNELS*SAMPLE_WIDTH  per-channel constant sample
- dac_dds_format  in  1  1: invert MSB of every output sample
- dma_data  in  NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH  DMA samples
- dma_valid  in  1  DMA word valid
- dma_ready  out  1  datapath accepts DMA word
- dac_data  out  NUM_CHANNELS*DATA_PATH_WIDTH*SAMPLE_WIDTH  to framer
- dac_valid  out  1  dac_data carries live samples
- dac_dunf  out  1  single-cycle underflow pulse
- dac_unf_clr  in  1  clear underflow counter
- dac_unf_count  out  16  saturating underflow cycle count
- dac_state  out  2  0 IDLE, 1 ARMED, 2 RUN

## Operation
- Sample k of channel i occupies bits [(i*DATA_PATH_WIDTH+k)*SAMPLE_WIDTH +: SAMPLE_WIDTH]; k=0 is the earliest in time. dma_data uses the same layout.
- State machine:
  - IDLE: on dac_sync, go to ARMED if dac_ext_sync_en, else go to RUN.
  - ARMED: go to RUN on the first cycle with dac_ext_sync=1.
  - RUN, and any state: dac_stop goes to IDLE.
  - If dac_stop and dac_sync coincide, stop wins.
  - dac_sync in ARMED or RUN is ignored.
- dma_ready = (state==RUN) and at least one channel has dac_enable=1 and sel=0. Combinational from registered state and config.
- A DMA word is accepted when dma_valid and dma_ready are both high.
- Underflow: dma_ready=1 and dma_valid=0. The DMA-sourced lanes then output zero, or the last accepted word if UNDERFLOW_HOLD=1; the hold register resets to zero.
- Ramp:
  - One shared counter R (SAMPLE_WIDTH bits) is cleared on every entry to RUN.
  - Sample k = R+k mod 2^SAMPLE_WIDTH.
  - R advances by DATA_PATH_WIDTH every RUN cycle and wraps silently.
- Pattern: every sample of the channel equals its dac_pat_data slice.
- A disabled channel outputs zero whatever its select value.
- Outside RUN, dac_data is zero and dac_valid=0.
- Format conversion is applied last, to every sample including zeros: dac_dds_format=1 inverts the MSB, so zero becomes 0x8000 for 16-bit samples.
- dac_unf_count increments on each underflow cycle and saturates at 0xFFFF. dac_unf_clr zeroes it, and clear wins over a coincident increment.

## Timing
- Reset values: state IDLE, dac_data 0, dac_valid 0, dma_ready 0, dac_dunf 0, dac_unf_count 0, R 0, hold register 0.
- dac_sync at cycle n (ext sync disabled): dac_state=RUN at n+1, dma_ready may assert at n+1, dac_valid=1 at n+2.
- Output latency is one register: data accepted, or selected, in cycle m appears on dac_data with dac_valid at m+1.
- dac_dunf and the counter update are registered, one cycle after the underflow cycle.
- dac_stop at cycle n: dma_ready=0 at n+1, dac_valid=0 and dac_data=0 at n+2.
- dac_rst asserted mid-RUN: all registers hold reset values from the next edge; no DMA word is accepted in any cycle where dac_rst=1.
- Config inputs are sampled every cycle; a select change is visible at the output one cycle later without a glitch cycle.

## Test plan
- Reset, then dac_sync with ext_sync_en=0, both channels on DMA, dma_valid=1 with a counting word: dac_valid rises 2 cycles after dac_sync and dac_data equals the dma_data of the previous cycle, bit-exact.
- ext_sync_en=1, dac_sync, then dac_ext_sync after 10 cycles: state stays ARMED for 10 cycles and dma_ready=0 throughout; RUN follows the cycle after dac_ext_sync.
- Ch0 ramp, ch1 pattern 0x1234, DATA_PATH_WIDTH=4, 16-bit: ch0 words read 0,1,2,3 / 4,5,6,7 …, wrap 0xFFFC..0xFFFF then 0,1,2,3; ch1 constant 0x1234.
- Underflow: drop dma_valid for 3 cycles, UNDERFLOW_HOLD=0 then 1: three dac_dunf pulses, count=3; DMA lanes zero, or repeating the last word; dac_unf_clr with a coincident underflow gives count=0.
- dac_dds_format=1, ch0 disabled: ch0 samples 0x8000; DMA sample 0x7FFF becomes 0xFFFF.
- dac_stop and dac_sync in the same cycle in RUN: goes to IDLE. dac_rst mid-RUN: outputs zero next cycle, and the ramp restarts at 0 on the next RUN.
